interboard_link_n: RTL and testbench

INTERBOARD_LINK_N -- requirements
Module: interboard_link_n

---
 rtl/interboard_link_n_pkg.sv | 33 +++
 rtl/interboard_link_n_fifo.sv | 80 ++++++++
 rtl/interboard_link_n.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_interboard_link_n.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/interboard_link_n_pkg.sv
// -----------------------------------------------------------------------------
// interboard_link_n_pkg
//   Shared definitions for the interboard link: TX/RX handshake state
//   encodings, message geometry helpers and the retry back-off length.
// -----------------------------------------------------------------------------
package interboard_link_n_pkg;

  // Idle cycles between a timed-out request and the retry of the same message.
  localparam int BACKOFF_LEN = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_WAIT_REL,
    TX_BACKOFF
  } tx_state_e;

  typedef enum logic {
    RX_IDLE,
    RX_ACK
  } rx_state_e;

  // Width of a packed {type, number} message.
  function automatic int msg_width(input int type_w, input int num_w);
    return type_w + num_w;
  endfunction

  // Number of bus beats needed to carry msg_w bits over a data_w bus.
  function automatic int beat_count(input int msg_w, input int data_w);
    return (msg_w + data_w - 1) / data_w;
  endfunction

endpackage

// File: rtl/interboard_link_n_fifo.sv
// -----------------------------------------------------------------------------
// link_fifo
//   Synchronous show-ahead FIFO holding outgoing messages. Full and empty are
//   registered; one write and one pop may happen in the same cycle.
//   Ports:
//     clk, rst         - clock, synchronous active-high reset
//     wr_en_i          - push strobe (ignored while full)
//     wr_data_i        - data to push
//     rd_en_i          - pop strobe (ignored while empty)
//     rd_data_o        - current head entry
//     full_o, empty_o  - registered occupancy flags
// -----------------------------------------------------------------------------
module link_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             do_wr, do_rd;

  assign do_wr = wr_en_i && !full_q;
  assign do_rd = rd_en_i && !empty_q;

  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers and flags decide what is valid, so clearing it would just cost
  // a reset fan-out on every entry.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/interboard_link_n.sv
// -----------------------------------------------------------------------------
// interboard_link_n
//   Four-phase request/acknowledge link between boards. Outgoing {type,number}
//   messages are queued, split into DATA_W-bit beats (LS chunk first) and sent
//   with timeout, back-off and bounded retry. Incoming beats are reassembled
//   and delivered as a one-cycle strobe. TX and RX are fully independent.
//   Ports:
//     clk, rst                          - clock, synchronous active-high reset
//     ctrl_en/ctrl_msg_type/ctrl_number - enqueue a message
//     inter_ready                       - TX queue not full
//     Request_out, inter_data_out       - TX request and beat
//     Ack_in                            - remote ack (asynchronous)
//     Request_in, inter_data_in         - remote request (async) and beat
//     Ack_out                           - RX ack
//     interboard_en/_msg_type/_number   - received message strobe and fields
//     interboard_rst                    - strobe when RST_TYPE is received
//     link_error                        - sticky: a message was dropped
// -----------------------------------------------------------------------------
module interboard_link_n
  import interboard_link_n_pkg::*;
#(
  parameter int                DATA_W     = 6,
  parameter int                TYPE_W     = 3,
  parameter int                NUM_W      = 5,
  parameter int                FIFO_DEPTH = 4,
  parameter int                TIMEOUT    = 50000,
  parameter int                MAX_RETRY  = 3,
  parameter logic [TYPE_W-1:0] RST_TYPE   = 3'd7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_en,
  input  logic [TYPE_W-1:0] ctrl_msg_type,
  input  logic [NUM_W-1:0]  ctrl_number,
  output logic              inter_ready,
  output logic              Request_out,
  output logic [DATA_W-1:0] inter_data_out,
  input  logic              Ack_in,
  input  logic              Request_in,
  input  logic [DATA_W-1:0] inter_data_in,
  output logic              Ack_out,
  output logic              interboard_en,
  output logic [TYPE_W-1:0] interboard_msg_type,
  output logic [NUM_W-1:0]  interboard_number,
  output logic              interboard_rst,
  output logic              link_error
);

  localparam int MSG_W   = msg_width(TYPE_W, NUM_W);
  localparam int BEATS   = beat_count(MSG_W, DATA_W);
  localparam int PAD_W   = BEATS * DATA_W;
  localparam int BEAT_W  = $clog2(BEATS + 1);
  localparam int TMO_W   = $clog2(TIMEOUT + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam int BO_W    = $clog2(BACKOFF_LEN);

  // ---------------------------------------------------------------------------
  // TX queue
  // ---------------------------------------------------------------------------
  logic [MSG_W-1:0] fifo_head;
  logic             fifo_full, fifo_empty, fifo_pop;

  link_fifo #(.WIDTH(MSG_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (ctrl_en),
    .wr_data_i ({ctrl_msg_type, ctrl_number}),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign inter_ready = !fifo_full;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers for the asynchronous handshake inputs
  // ---------------------------------------------------------------------------
  logic [1:0] ack_sync_q, req_sync_q;
  logic       ack_s, req_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync_q <= '0;
      req_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[0], Ack_in};
      req_sync_q <= {req_sync_q[0], Request_in};
    end
  end

  assign ack_s = ack_sync_q[1];
  assign req_s = req_sync_q[1];

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  tx_state_e          tx_state_q, tx_state_d;
  logic [PAD_W-1:0]   tx_msg_q, tx_msg_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_req_q, tx_req_d;
  logic [BEAT_W-1:0]  tx_beat_q, tx_beat_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [BO_W-1:0]    bo_q, bo_d;
  logic               err_q, err_d;
  logic [PAD_W-1:0]   head_pad;

  // Zero-pads the message so the last beat carries zeros above MSG_W.
  assign head_pad = PAD_W'(fifo_head);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_msg_d   = tx_msg_q;
    tx_data_d  = tx_data_q;
    tx_req_d   = tx_req_q;
    tx_beat_d  = tx_beat_q;
    tmo_d      = tmo_q;
    retry_d    = retry_q;
    bo_d       = bo_q;
    err_d      = err_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          tx_msg_d   = head_pad;
          tx_data_d  = head_pad[DATA_W-1:0];
          tx_beat_d  = '0;
          retry_d    = '0;
          tmo_d      = '0;
          tx_req_d   = 1'b1;
          tx_state_d = TX_REQ;
        end
      end
      TX_REQ: begin
        if (ack_s) begin
          tx_req_d   = 1'b0;
          tx_state_d = TX_WAIT_REL;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          tx_req_d = 1'b0;
          tmo_d    = '0;
          // This timeout would push the retry count past MAX_RETRY: drop.
          if (retry_q == RETRY_W'(MAX_RETRY)) begin
            fifo_pop   = 1'b1;
            err_d      = 1'b1;
            tx_state_d = TX_IDLE;
          end else begin
            retry_d    = retry_q + 1'b1;
            bo_d       = '0;
            tx_state_d = TX_BACKOFF;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      TX_WAIT_REL: begin
        if (!ack_s) begin
          if (tx_beat_q == BEAT_W'(BEATS - 1)) begin
            fifo_pop   = 1'b1;
            tx_state_d = TX_IDLE;
          end else begin
            tx_beat_d  = tx_beat_q + 1'b1;
            // Data changes only here, while Request_out is low.
            tx_data_d  = tx_msg_q[int'(tx_beat_d)*DATA_W +: DATA_W];
            tmo_d      = '0;
            tx_req_d   = 1'b1;
            tx_state_d = TX_REQ;
          end
        end
      end
      TX_BACKOFF: begin
        if (bo_q == BO_W'(BACKOFF_LEN - 1)) begin
          tx_beat_d  = '0;
          tx_data_d  = tx_msg_q[DATA_W-1:0];
          tmo_d      = '0;
          tx_req_d   = 1'b1;
          tx_state_d = TX_REQ;
        end else begin
          bo_d = bo_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_msg_q   <= '0;
      tx_data_q  <= '0;
      tx_req_q   <= 1'b0;
      tx_beat_q  <= '0;
      tmo_q      <= '0;
      retry_q    <= '0;
      bo_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_msg_q   <= tx_msg_d;
      tx_data_q  <= tx_data_d;
      tx_req_q   <= tx_req_d;
      tx_beat_q  <= tx_beat_d;
      tmo_q      <= tmo_d;
      retry_q    <= retry_d;
      bo_q       <= bo_d;
      err_q      <= err_d;
    end
  end

  assign Request_out    = tx_req_q;
  assign inter_data_out = tx_data_q;
  assign link_error     = err_q;

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  rx_state_e         rx_state_q, rx_state_d;
  logic [MSG_W-1:0]  rx_buf_q, rx_buf_d;
  logic [BEAT_W-1:0] rx_beat_q, rx_beat_d;
  logic              rx_ack_q, rx_ack_d;
  logic              rx_en_q, rx_en_d;
  logic              rx_rst_q, rx_rst_d;
  logic [TYPE_W-1:0] rx_type_q, rx_type_d;
  logic [NUM_W-1:0]  rx_num_q, rx_num_d;
  logic [PAD_W-1:0]  rx_wide;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_buf_d   = rx_buf_q;
    rx_beat_d  = rx_beat_q;
    rx_ack_d   = rx_ack_q;
    rx_en_d    = 1'b0;
    rx_rst_d   = 1'b0;
    rx_type_d  = rx_type_q;
    rx_num_d   = rx_num_q;
    rx_wide    = PAD_W'(rx_buf_q);
    case (rx_state_q)
      RX_IDLE: begin
        // Only reached with the previous request released, so this is the
        // first cycle the synced request is seen high.
        if (req_s) begin
          rx_wide[int'(rx_beat_q)*DATA_W +: DATA_W] = inter_data_in;
          rx_buf_d   = MSG_W'(rx_wide);
          rx_ack_d   = 1'b1;
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK: begin
        if (!req_s) begin
          rx_ack_d   = 1'b0;
          rx_state_d = RX_IDLE;
          if (rx_beat_q == BEAT_W'(BEATS - 1)) begin
            rx_beat_d = '0;
            rx_en_d   = 1'b1;
            rx_type_d = rx_buf_q[MSG_W-1:NUM_W];
            rx_num_d  = rx_buf_q[NUM_W-1:0];
            rx_rst_d  = (rx_buf_q[MSG_W-1:NUM_W] == RST_TYPE);
          end else begin
            rx_beat_d = rx_beat_q + 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_buf_q   <= '0;
      rx_beat_q  <= '0;
      rx_ack_q   <= 1'b0;
      rx_en_q    <= 1'b0;
      rx_rst_q   <= 1'b0;
      rx_type_q  <= '0;
      rx_num_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_buf_q   <= rx_buf_d;
      rx_beat_q  <= rx_beat_d;
      rx_ack_q   <= rx_ack_d;
      rx_en_q    <= rx_en_d;
      rx_rst_q   <= rx_rst_d;
      rx_type_q  <= rx_type_d;
      rx_num_q   <= rx_num_d;
    end
  end

  assign Ack_out             = rx_ack_q;
  assign interboard_en       = rx_en_q;
  assign interboard_rst      = rx_rst_q;
  assign interboard_msg_type = rx_type_q;
  assign interboard_number   = rx_num_q;

endmodule

// File: tb/tb_interboard_link_n.sv
// -----------------------------------------------------------------------------
// tb_interboard_link_n
//   Instance "dut" runs with defaults and is looped back on itself
//   (Request_out->Request_in, data out->in, Ack_out->Ack_in).
//   Instance "dut_t" has TIMEOUT=20, MAX_RETRY=1 and Ack_in tied low.
// -----------------------------------------------------------------------------
module tb_interboard_link_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Loopback instance
  logic       a_ctrl_en;
  logic [2:0] a_type;
  logic [4:0] a_num;
  logic       a_ready, a_req, a_ack, a_en, a_rstp, a_err;
  logic [5:0] a_data;
  logic [2:0] a_otype;
  logic [4:0] a_onum;

  interboard_link_n dut (
    .clk                 (clk),
    .rst                 (rst),
    .ctrl_en             (a_ctrl_en),
    .ctrl_msg_type       (a_type),
    .ctrl_number         (a_num),
    .inter_ready         (a_ready),
    .Request_out         (a_req),
    .inter_data_out      (a_data),
    .Ack_in              (a_ack),
    .Request_in          (a_req),
    .inter_data_in       (a_data),
    .Ack_out             (a_ack),
    .interboard_en       (a_en),
    .interboard_msg_type (a_otype),
    .interboard_number   (a_onum),
    .interboard_rst      (a_rstp),
    .link_error          (a_err)
  );

  // Timeout instance
  logic       b_ctrl_en;
  logic [2:0] b_type;
  logic [4:0] b_num;
  logic       b_ready, b_req, b_ack_out, b_en, b_rstp, b_err;
  logic [5:0] b_data;
  logic [2:0] b_otype;
  logic [4:0] b_onum;

  interboard_link_n #(.TIMEOUT(20), .MAX_RETRY(1)) dut_t (
    .clk                 (clk),
    .rst                 (rst),
    .ctrl_en             (b_ctrl_en),
    .ctrl_msg_type       (b_type),
    .ctrl_number         (b_num),
    .inter_ready         (b_ready),
    .Request_out         (b_req),
    .inter_data_out      (b_data),
    .Ack_in              (1'b0),
    .Request_in          (1'b0),
    .inter_data_in       (6'd0),
    .Ack_out             (b_ack_out),
    .interboard_en       (b_en),
    .interboard_msg_type (b_otype),
    .interboard_number   (b_onum),
    .interboard_rst      (b_rstp),
    .link_error          (b_err)
  );

  int assertions = 0;
  int failures   = 0;

  // ---------------------------------------------------------------------------
  // Monitors (sample on the falling edge)
  // ---------------------------------------------------------------------------
  logic       a_req_prev = 1'b0;
  logic [5:0] a_beats[$];
  logic [2:0] a_del_type[$];
  logic [4:0] a_del_num[$];
  logic       a_del_rst[$];
  int         a_rst_pulses = 0;
  int         b_pulse_len[$];
  int         b_gap[$];
  int         b_run = 0;
  int         b_low = 0;

  always @(negedge clk) begin
    if (a_req === 1'b1 && a_req_prev !== 1'b1) a_beats.push_back(a_data);
    a_req_prev = a_req;
    if (a_en === 1'b1) begin
      a_del_type.push_back(a_otype);
      a_del_num.push_back(a_onum);
      a_del_rst.push_back(a_rstp);
    end
    if (a_rstp === 1'b1) a_rst_pulses++;
    if (b_req === 1'b1) begin
      if (b_run == 0 && b_pulse_len.size() > 0) b_gap.push_back(b_low);
      b_run++;
    end else begin
      if (b_run > 0) begin
        b_pulse_len.push_back(b_run);
        b_run = 0;
        b_low = 0;
      end
      b_low++;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic send_a(input logic [2:0] t, input logic [4:0] n);
    @(negedge clk);
    a_ctrl_en = 1'b1;
    a_type    = t;
    a_num     = n;
    @(negedge clk);
    a_ctrl_en = 1'b0;
  endtask

  task automatic wait_deliveries(input int target, input int budget);
    for (int i = 0; i < budget && a_del_type.size() < target; i++) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    a_ctrl_en = 1'b0; a_type = '0; a_num = '0;
    b_ctrl_en = 1'b0; b_type = '0; b_num = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    assertions++; if (a_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", a_req); end
    assertions++; if (a_data !== 6'd0) begin failures++; $display("FAIL reset_data: got %h expected 00", a_data); end
    assertions++; if (a_ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b expected 0", a_ack); end
    assertions++; if (a_en !== 1'b0) begin failures++; $display("FAIL reset_en: got %b expected 0", a_en); end
    assertions++; if (a_otype !== 3'd0) begin failures++; $display("FAIL reset_type: got %0d expected 0", a_otype); end
    assertions++; if (a_onum !== 5'd0) begin failures++; $display("FAIL reset_num: got %0d expected 0", a_onum); end
    assertions++; if (a_rstp !== 1'b0) begin failures++; $display("FAIL reset_rstp: got %b expected 0", a_rstp); end
    assertions++; if (a_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", a_err); end
    assertions++; if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", a_ready); end
    assertions++; if (b_req !== 1'b0) begin failures++; $display("FAIL reset_t_req: got %b expected 0", b_req); end
    assertions++; if (b_err !== 1'b0) begin failures++; $display("FAIL reset_t_err: got %b expected 0", b_err); end
  endtask

  task automatic test_loopback();
    int b0 = a_beats.size();
    int d0 = a_del_type.size();
    logic [5:0] beat0, beat1;
    send_a(3'd2, 5'd17);
    wait_deliveries(d0 + 1, 300);
    repeat (60) @(negedge clk);
    // {3'b010, 5'b10001} = 8'b01_010001 -> beat0 6'h11, beat1 6'h01 (zero-padded)
    assertions++; if (a_beats.size() - b0 !== 2) begin failures++; $display("FAIL loop_beat_count: got %0d expected 2", a_beats.size() - b0); end
    beat0 = (a_beats.size() > b0)     ? a_beats[b0]     : 6'hxx;
    beat1 = (a_beats.size() > b0 + 1) ? a_beats[b0 + 1] : 6'hxx;
    assertions++; if (beat0 !== 6'h11) begin failures++; $display("FAIL loop_beat0: got %h expected 11", beat0); end
    assertions++; if (beat1 !== 6'h01) begin failures++; $display("FAIL loop_beat1: got %h expected 01", beat1); end
    assertions++; if (a_del_type.size() - d0 !== 1) begin failures++; $display("FAIL loop_deliveries: got %0d expected 1", a_del_type.size() - d0); end
    if (a_del_type.size() > d0) begin
      assertions++; if (a_del_type[d0] !== 3'd2) begin failures++; $display("FAIL loop_type: got %0d expected 2", a_del_type[d0]); end
      assertions++; if (a_del_num[d0] !== 5'd17) begin failures++; $display("FAIL loop_num: got %0d expected 17", a_del_num[d0]); end
      assertions++; if (a_del_rst[d0] !== 1'b0) begin failures++; $display("FAIL loop_rstp: got %b expected 0", a_del_rst[d0]); end
    end
    // Fields hold after the strobe has gone away.
    assertions++; if (a_en !== 1'b0) begin failures++; $display("FAIL loop_en_low: got %b expected 0", a_en); end
    assertions++; if (a_otype !== 3'd2 || a_onum !== 5'd17) begin failures++; $display("FAIL loop_hold: got %0d/%0d expected 2/17", a_otype, a_onum); end
  endtask

  task automatic test_back_to_back();
    int d0 = a_del_type.size();
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin
        assertions++; if (a_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_3: got %b expected 1", a_ready); end
      end
      if (k == 4) begin
        assertions++; if (a_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_4: got %b expected 0", a_ready); end
      end
      a_ctrl_en = 1'b1;
      a_type    = 3'(k + 1);
      a_num     = 5'(10 + k);
      @(negedge clk);
    end
    a_ctrl_en = 1'b0;
    assertions++; if (a_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_5: got %b expected 0", a_ready); end
    wait_deliveries(d0 + 4, 600);
    repeat (100) @(negedge clk);
    assertions++; if (a_del_type.size() - d0 !== 4) begin failures++; $display("FAIL b2b_count: got %0d expected 4", a_del_type.size() - d0); end
    for (int k = 0; k < 4; k++) begin
      if (a_del_type.size() > d0 + k) begin
        assertions++;
        if (a_del_type[d0 + k] !== 3'(k + 1) || a_del_num[d0 + k] !== 5'(10 + k)) begin
          failures++;
          $display("FAIL b2b_order[%0d]: got %0d/%0d expected %0d/%0d", k, a_del_type[d0 + k], a_del_num[d0 + k], k + 1, 10 + k);
        end
      end
    end
    assertions++; if (a_ready !== 1'b1) begin failures++; $display("FAIL b2b_drained: got %b expected 1", a_ready); end
  endtask

  task automatic test_rst_msg();
    int d0 = a_del_type.size();
    int p0 = a_rst_pulses;
    send_a(3'd7, 5'd0);
    wait_deliveries(d0 + 1, 300);
    repeat (10) @(negedge clk);
    assertions++; if (a_del_type.size() - d0 !== 1) begin failures++; $display("FAIL rstmsg_count: got %0d expected 1", a_del_type.size() - d0); end
    if (a_del_type.size() > d0) begin
      assertions++; if (a_del_rst[d0] !== 1'b1) begin failures++; $display("FAIL rstmsg_same_cycle: got %b expected 1", a_del_rst[d0]); end
      assertions++; if (a_del_type[d0] !== 3'd7 || a_del_num[d0] !== 5'd0) begin failures++; $display("FAIL rstmsg_fields: got %0d/%0d expected 7/0", a_del_type[d0], a_del_num[d0]); end
    end
    assertions++; if (a_rst_pulses - p0 !== 1) begin failures++; $display("FAIL rstmsg_pulses: got %0d expected 1", a_rst_pulses - p0); end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    b_ctrl_en = 1'b1; b_type = 3'd4; b_num = 5'd9;
    @(negedge clk);
    b_ctrl_en = 1'b0;
    for (int i = 0; i < 300 && b_err !== 1'b1; i++) @(negedge clk);
    repeat (60) @(negedge clk);
    assertions++; if (b_err !== 1'b1) begin failures++; $display("FAIL tmo_link_error: got %b expected 1", b_err); end
    assertions++; if (b_pulse_len.size() !== 2) begin failures++; $display("FAIL tmo_pulses: got %0d expected 2", b_pulse_len.size()); end
    for (int k = 0; k < 2; k++) begin
      if (b_pulse_len.size() > k) begin
        assertions++; if (b_pulse_len[k] !== 20) begin failures++; $display("FAIL tmo_len[%0d]: got %0d expected 20", k, b_pulse_len[k]); end
      end
    end
    if (b_gap.size() > 0) begin
      assertions++; if (b_gap[0] !== 16) begin failures++; $display("FAIL tmo_backoff: got %0d expected 16", b_gap[0]); end
    end
    assertions++; if (b_req !== 1'b0 || b_ready !== 1'b1) begin failures++; $display("FAIL tmo_idle: got req=%b ready=%b expected req=0 ready=1", b_req, b_ready); end
  endtask

  task automatic test_reset_mid();
    int d0;
    int b0;
    int i;
    send_a(3'd3, 5'd5);
    send_a(3'd1, 5'd6);
    for (i = 0; i < 50 && a_req !== 1'b1; i++) @(negedge clk);
    assertions++; if (a_req !== 1'b1) begin failures++; $display("FAIL midrst_req_seen: got %b expected 1", a_req); end
    d0 = a_del_type.size();
    rst = 1'b1;
    @(negedge clk);
    assertions++; if (a_req !== 1'b0) begin failures++; $display("FAIL midrst_req: got %b expected 0", a_req); end
    assertions++; if (a_ready !== 1'b1 || a_ack !== 1'b0) begin failures++; $display("FAIL midrst_state: got ready=%b ack=%b expected 1/0", a_ready, a_ack); end
    rst = 1'b0;
    b0 = a_beats.size();
    repeat (200) @(negedge clk);
    assertions++; if (a_del_type.size() !== d0) begin failures++; $display("FAIL midrst_delivery: got %0d expected %0d", a_del_type.size(), d0); end
    assertions++; if (a_beats.size() !== b0) begin failures++; $display("FAIL midrst_fifo_empty: got %0d new requests expected 0", a_beats.size() - b0); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_rst_msg();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
